mlu_iter: RTL and testbench
===========================

# mlu_iter

Parametrised iterative multiply/multiply-accumulate unit; next-generation replacement for the CPU's fixed 32-bit 16x-slice MAC datapath. It holds the MACH/MACL accumulator pair, runs multiplies as W/SW shift-add passes through one (W+1)x(SW+1) signed multiplier, and exposes a valid/ready command handshake plus a completion pulse. It sits beside the register file / memory-access units in the execute stage and replaces stall-on-busy decoding with an explicit ready signal.

## Interface
- W, 32, operand width and MACH/MACL width
- SW, 16, multiplier slice width; W % SW == 0, SW >= 2; NP = W/SW passes
- SATW, 48, saturating-accumulate result width; W < SATW <= 2W
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  command present
- op_ready  out  1  unit idle, command accepted on edge where op_valid & op_ready
- op_code  in  3  0 NOP, 1 CLR, 2 LDH, 3 LDL, 4 MUL, 5 DMULU, 6 DMULS, 7 MAC
- sat  in  1  saturate MAC (SR.S); sampled at accept
- a, b  in  W  operands; sampled at accept
- mach, macl  out  W  accumulator registers
- busy  out  1  multi-pass operation in flight (= ~op_ready)
- done  out  1  one-cycle pulse: result written this cycle
- ovf  out  1  one-cycle pulse with done: MAC saturated

## Operation
- States IDLE, RUN. IDLE: op_ready=1. Accept of MUL/DMULU/DMULS/MAC -> RUN, pass counter k=0, operands and op/sat captured.
- NOP: accepted, no effect, no done. CLR: mach=macl=0. LDH: mach=a. LDL: macl=a. These complete on the accept edge; done high the following cycle; stay IDLE.
- RUN pass k (k=0..NP-1): prod += A * slice_k(B) << (k*SW). A is a sign-extended (DMULS, MAC) or zero-extended to W+1 bits. slice_k unsigned except top slice sign-extended for DMULS/MAC. prod is 2W bits, cleared at accept.
- Final pass edge (k=NP-1) writes result, returns to IDLE:
  - MUL: macl = prod[W-1:0]; mach unchanged.
  - DMULU/DMULS: {mach,macl} = prod.
  - MAC, sat=0: {mach,macl} = {mach,macl} + prod, modulo 2^(2W).
  - MAC, sat=1: sum computed at 2W+1 bits; if outside signed SATW range, clamp to +2^(SATW-1)-1 or -2^(SATW-1), sign-extended to 2W; ovf=1.
- mach/macl keep old values during RUN; intermediate state never visible.
- op_code values outside 0..7 impossible (3 bits); no illegal state.

## Timing
- Reset (async assert, sync release): mach=0, macl=0, done=0, ovf=0, busy=0, op_ready=1, state IDLE, k=0.
- Multi-pass latency: accept edge T; passes on edges T+1..T+NP; result visible and done/ovf high in cycle after T+NP.
- op_ready rises in the done cycle; a new command may be accepted on that edge (issue interval NP+1 cycles for multiplies, 1 cycle for CLR/LDH/LDL/NOP).
- Single-cycle ops back-to-back: each accepted every edge; done pulses merge into continuous high.
- Reset asserted during RUN: operation aborted, no done, all outputs to reset values immediately.
- op_valid low in IDLE: no state change; inputs ignored while busy.

## Configuration
- MLU_SAT_EN defined: saturation path, SATW range checking, and ovf generation present as above.
- Not defined: sat input ignored, MAC always wraps modulo 2^(2W), ovf tied 0; SATW unused.

## Test plan
- W=32,SW=16: DMULS a=0xFFFFFFFF b=2 -> mach=0xFFFFFFFF macl=0xFFFFFFFE; done exactly 2 cycles after accept edge's cycle +1 (edge T+2).
- DMULU a=0xFFFFFFFF b=2 -> mach=0x00000001 macl=0xFFFFFFFE; MUL a=0x00010000 b=0x00010000 after LDH 0x1234 -> macl=0, mach=0x00001234.
- LDH 0x00007FFF, LDL 0xFFFFFFFF, MAC a=1 b=1 sat=1 -> mach=0x00007FFF macl=0xFFFFFFFF, ovf=1 (with MLU_SAT_EN); sat=0 -> mach=0x00008000 macl=0.
- LDH 0xFFFF8000, LDL 0, MAC a=-1 b=1 sat=1 -> clamp mach=0xFFFF8000 macl=0, ovf=1; without MLU_SAT_EN -> mach=0xFFFF7FFF macl=0xFFFFFFFF, ovf=0.
- rst low one cycle after MAC accept -> mach=macl=0, op_ready=1, no done pulse thereafter.
- op_valid held high with MUL then CLR -> CLR accepted in MUL's done cycle; op_ready low exactly NP cycles; W=64,SW=16 variant DMULS -1*-1 -> {mach,macl}=1 after 4 passes.

Source files
------------

// File: rtl/mlu_iter.sv
// Iterative multiply / multiply-accumulate unit holding the MACH/MACL pair; NP=W/SW shift-add passes.
// Optional saturating MAC (SATW-bit signed clamp, ovf pulse) is built when MLU_SAT_EN is defined.
module mlu_iter #(
  parameter int W    = 32,
  parameter int SW   = 16,
  parameter int SATW = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_code,
  input  logic         sat,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] mach,
  output logic [W-1:0] macl,
  output logic         busy,
  output logic         done,
  output logic         ovf
);
  localparam int NP = W / SW;
  localparam int KW = (NP > 1) ? $clog2(NP) : 1;
  localparam int MW = W + SW + 2;
  localparam int PW = 2 * W + SW + 2;

  localparam logic [2:0] OP_NOP = 3'd0, OP_CLR = 3'd1, OP_LDH = 3'd2, OP_LDL = 3'd3,
                         OP_MUL = 3'd4, OP_DMULU = 3'd5, OP_DMULS = 3'd6, OP_MAC = 3'd7;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [KW-1:0]    r_k;
  logic [2:0]       r_op;
  logic             r_sat;
  logic [W:0]       r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_prod;
  logic [W-1:0]     r_mach, r_macl;
  logic             r_done, r_ovf;

  logic             w_accept, w_last, w_sgn;
  logic [SW:0]      w_slice;
  logic [MW-1:0]    w_ax, w_sx, w_mul;
  logic [PW-1:0]    w_shift;
  logic [2*W-1:0]   w_prod_nxt, w_acc, w_res, w_smax, w_smin;
  logic [2*W:0]     w_sum;
  logic             w_ovf_nxt;
  logic             w_unused;

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    op_ready    = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        w_accept = op_valid;
        if (op_valid && op_code[2]) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_last = (r_k == KW'(NP - 1));
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One pass: signed (W+1)x(SW+1) partial product, aligned to slice k. r_b shifts down each pass.
  assign w_sgn      = (r_op == OP_DMULS) || (r_op == OP_MAC);
  assign w_slice    = {w_sgn & (r_k == KW'(NP - 1)) & r_b[SW-1], r_b[SW-1:0]};
  assign w_ax       = {{(SW+1){r_a[W]}}, r_a};
  assign w_sx       = {{(W+1){w_slice[SW]}}, w_slice};
  assign w_mul      = w_ax * w_sx;
  assign w_shift    = {{(PW-MW){w_mul[MW-1]}}, w_mul} << (r_k * SW);
  assign w_prod_nxt = r_prod + w_shift[2*W-1:0];

  assign w_acc  = {r_mach, r_macl};
  assign w_sum  = {w_acc[2*W-1], w_acc} + {w_prod_nxt[2*W-1], w_prod_nxt};
  assign w_smax = {{(2*W-SATW+1){1'b0}}, {(SATW-1){1'b1}}};
  assign w_smin = ~w_smax;

  always_comb begin
    w_res     = w_prod_nxt;
    w_ovf_nxt = 1'b0;
    case (r_op)
      OP_MUL: w_res = {r_mach, w_prod_nxt[W-1:0]};
      OP_MAC: begin
        w_res = w_sum[2*W-1:0];
`ifdef MLU_SAT_EN
        // Out of SATW range when the bits above the SATW sign bit disagree.
        if (r_sat && !((&w_sum[2*W:SATW-1]) || !(|w_sum[2*W:SATW-1]))) begin
          w_res     = w_sum[2*W] ? w_smin : w_smax;
          w_ovf_nxt = 1'b1;
        end
`endif
      end
      default: w_res = w_prod_nxt;
    endcase
  end

`ifdef MLU_SAT_EN
  assign w_unused = ^{w_shift[PW-1:2*W]};
`else
  assign w_unused = ^{w_shift[PW-1:2*W], r_sat, w_sum[2*W], w_smax, w_smin};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k    <= '0;
      r_op   <= OP_NOP;
      r_sat  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_mach <= '0;
      r_macl <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      if (w_accept) begin
        case (op_code)
          OP_CLR: begin r_mach <= '0; r_macl <= '0; r_done <= 1'b1; end
          OP_LDH: begin r_mach <= a; r_done <= 1'b1; end
          OP_LDL: begin r_macl <= a; r_done <= 1'b1; end
          OP_MUL, OP_DMULU, OP_DMULS, OP_MAC: begin
            r_op   <= op_code;
            r_sat  <= sat;
            r_a    <= {((op_code == OP_DMULS) || (op_code == OP_MAC)) & a[W-1], a};
            r_b    <= b;
            r_prod <= '0;
            r_k    <= '0;
          end
          default: ;
        endcase
      end else if (r_state == S_RUN) begin
        r_prod <= w_prod_nxt;
        r_b    <= r_b >> SW;
        r_k    <= r_k + 1'b1;
        if (w_last) begin
          {r_mach, r_macl} <= w_res;
          r_done           <= 1'b1;
          r_ovf            <= w_ovf_nxt;
          r_k              <= '0;
        end
      end
    end
  end

  assign mach = r_mach;
  assign macl = r_macl;
  assign busy = ~op_ready;
  assign done = r_done;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_mlu_iter.sv
// Randomized + directed bench for mlu_iter against an arithmetic model of the MACH/MACL pair.
module tb_mlu_iter;
  localparam int W = 32, SW = 16, NP = W / SW;
`ifdef MLU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic op_valid = 1'b0, op_ready, sat = 1'b0, busy, done, ovf;
  logic [2:0] op_code = 3'd0;
  logic [W-1:0] a = '0, b = '0, mach, macl;

  logic v64 = 1'b0, rdy64, busy64, done64, ovf64;
  logic [2:0] code64 = 3'd0;
  logic [63:0] a64 = '0, b64 = '0, mach64, macl64;

  always #5 clk = ~clk;

  mlu_iter #(.W(W), .SW(SW), .SATW(48)) u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .sat(sat), .a(a), .b(b), .mach(mach), .macl(macl), .busy(busy), .done(done), .ovf(ovf));

  mlu_iter #(.W(64), .SW(16), .SATW(96)) u_dut64 (
    .clk(clk), .rst(rst), .op_valid(v64), .op_ready(rdy64), .op_code(code64),
    .sat(1'b0), .a(a64), .b(b64), .mach(mach64), .macl(macl64), .busy(busy64), .done(done64), .ovf(ovf64));

  int n_chk = 0, n_err = 0;
  logic [63:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: accumulator as a 64-bit value, products via plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib, input logic is);
    int sa, sb;
    longint pr;
    logic signed [127:0] sum, mx, mn;
    sa = ia; sb = ib;
    pr = longint'(sa) * longint'(sb);
    mx = (128'sd1 <<< 47) - 128'sd1;
    mn = -(128'sd1 <<< 47);
    m_ovf = 1'b0;
    case (op)
      3'd1: m_acc = '0;
      3'd2: m_acc[63:32] = ia;
      3'd3: m_acc[31:0] = ia;
      3'd4: m_acc[31:0] = ia * ib;
      3'd5: m_acc = {32'd0, ia} * {32'd0, ib};
      3'd6: m_acc = pr;
      3'd7: begin
        sum = {{64{m_acc[63]}}, m_acc};
        sum = sum + {{64{pr[63]}}, pr};
        if (SAT_EN && is && (sum > mx || sum < mn)) begin
          sum   = (sum > mx) ? mx : mn;
          m_ovf = 1'b1;
        end
        m_acc = sum[63:0];
      end
      default: ;
    endcase
  endtask

  // Issue one command from IDLE (caller sits #1 after a rising edge) and check its completion.
  task automatic run(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                     input logic is, input string tag);
    int n;
    op_valid = 1'b1; op_code = op; a = ia; b = ib; sat = is;
    @(posedge clk); #1;
    op_valid = 1'b0; a = $urandom; b = $urandom; sat = 1'($urandom);
    model(op, ia, ib, is);
    n = 0;
    if (op[2]) begin
      chk({tag, " busy"}, busy, 1);
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, " latency"}, n, NP);
    end else begin
      chk({tag, " done"}, done, op != 3'd0);
    end
    chk({tag, " mach"}, mach, m_acc[63:32]);
    chk({tag, " macl"}, macl, m_acc[31:0]);
    chk({tag, " ovf"}, ovf, m_ovf);
    chk({tag, " ready"}, op_ready, 1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_7FFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic seen;
    repeat (2) @(posedge clk); #1;
    chk("rst mach", mach, 0);
    chk("rst macl", macl, 0);
    chk("rst done", done, 0);
    chk("rst ovf", ovf, 0);
    chk("rst busy", busy, 0);
    chk("rst ready", op_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    run(3'd6, 32'hFFFF_FFFF, 32'd2, 1'b0, "dmuls");
    chk("dmuls const", {mach, macl}, 64'hFFFF_FFFF_FFFF_FFFE);
    run(3'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, "dmulu");
    chk("dmulu const", {mach, macl}, 64'h0000_0001_FFFF_FFFE);
    run(3'd2, 32'h1234, 32'd0, 1'b0, "ldh");
    run(3'd4, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul");
    chk("mul const", {mach, macl}, 64'h0000_1234_0000_0000);

    run(3'd2, 32'h7FFF, 0, 0, "ldh"); run(3'd3, 32'hFFFF_FFFF, 0, 0, "ldl");
    run(3'd7, 32'd1, 32'd1, 1'b1, "mac sat hi");
    chk("mac sat hi const", {mach, macl, ovf},
        SAT_EN ? {64'h0000_7FFF_FFFF_FFFF, 1'b1} : {64'h0000_8000_0000_0000, 1'b0});
    run(3'd2, 32'h7FFF, 0, 0, "ldh"); run(3'd3, 32'hFFFF_FFFF, 0, 0, "ldl");
    run(3'd7, 32'd1, 32'd1, 1'b0, "mac wrap");
    chk("mac wrap const", {mach, macl}, 64'h0000_8000_0000_0000);
    run(3'd2, 32'hFFFF_8000, 0, 0, "ldh"); run(3'd3, 32'h0, 0, 0, "ldl");
    run(3'd7, 32'hFFFF_FFFF, 32'd1, 1'b1, "mac sat lo");
    chk("mac sat lo const", {mach, macl, ovf},
        SAT_EN ? {64'hFFFF_8000_0000_0000, 1'b1} : {64'hFFFF_7FFF_FFFF_FFFF, 1'b0});

    // Single-cycle ops back-to-back with op_valid held high.
    op_valid = 1'b1; op_code = 3'd2; a = 32'hA5A5_0001;
    @(posedge clk); #1; model(3'd2, 32'hA5A5_0001, 0, 0);
    chk("b2b ldh done", done, 1); chk("b2b ldh mach", mach, m_acc[63:32]);
    op_code = 3'd3; a = 32'h5A5A_0002;
    @(posedge clk); #1; model(3'd3, 32'h5A5A_0002, 0, 0);
    chk("b2b ldl done", done, 1); chk("b2b ldl macl", macl, m_acc[31:0]);
    op_code = 3'd0;
    @(posedge clk); #1;
    chk("b2b nop done", done, 0); chk("b2b nop acc", {mach, macl}, m_acc);
    op_valid = 1'b0;

    // MUL then CLR with op_valid held: CLR taken on the edge ending MUL's done cycle.
    op_valid = 1'b1; op_code = 3'd4; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    op_code = 3'd1;
    model(3'd4, 32'd3, 32'd5, 1'b0);
    n = 0;
    while (!op_ready && n < 20) begin n++; @(posedge clk); #1; end
    chk("held ready low cycles", n, NP);
    chk("held mul done", done, 1);
    chk("held mul macl", macl, 32'd15);
    @(posedge clk); #1;
    op_valid = 1'b0;
    model(3'd1, 0, 0, 0);
    chk("held clr done", done, 1);
    chk("held clr acc", {mach, macl}, 64'd0);

    for (int i = 0; i < 60; i++)
      run(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'($urandom), "rand");

    // Reset during RUN aborts the MAC with no done.
    run(3'd2, 32'hDEAD_BEEF, 0, 0, "pre-abort ldh");
    op_valid = 1'b1; op_code = 3'd7; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("abort mach", mach, 0); chk("abort macl", macl, 0);
    chk("abort ready", op_ready, 1); chk("abort done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    m_acc = '0;
    seen = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen |= done; end
    chk("abort no done", seen, 0);

    // 64-bit instance: four passes.
    v64 = 1'b1; code64 = 3'd6; a64 = '1; b64 = '1;
    @(posedge clk); #1;
    v64 = 1'b0;
    n = 0;
    while (!done64 && n < 20) begin @(posedge clk); #1; n++; end
    chk("w64 latency", n, 4);
    chk("w64 dmuls", {mach64, macl64}, 128'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
